// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: packs a decoded RV64I operation into a 32-bit
// instruction word and writes it to instruction memory at an
// auto-incrementing byte address using a held request / acknowledge.
//
// state   | meaning
// S_IDLE  | ready for a request; write pointer may be reloaded
// S_ENC   | encode latched fields and range-check the immediate
// S_WRITE | hold mem_we/mem_addr/mem_wdata until mem_ack
// S_ERR   | one-cycle err pulse, nothing written
module inst_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [63:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       inst_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam logic [3:0] OP_LD   = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SD   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_SLTI = 4'd5;
  localparam logic [3:0] OP_JALR = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_JAL  = 4'd8;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;

  logic [1:0]        r_state;
  logic [3:0]        r_op;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [63:0]       r_imm;
  logic [ADDR_W-1:0] r_ptr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_err_code;
  logic [15:0]       r_count;

  logic              w_accept;
  logic              w_short_ok;
  logic              w_long_ok;
  logic              w_illegal;
  logic              w_range_ok;
  logic [31:0]       w_word;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  // 12-bit signed range: every bit above bit 10 must match the sign
  assign w_short_ok = (&r_imm[63:11]) || (~|r_imm[63:11]);
  // 20-bit signed range for JAL
  assign w_long_ok  = (&r_imm[63:19]) || (~|r_imm[63:19]);

  // Pack the latched operation and select which range rule applies
  always_comb begin
    w_word     = '0;
    w_illegal  = 1'b0;
    w_range_ok = w_short_ok;
    case (r_op)
      OP_LD:   w_word = {r_imm[11:0], r_rs1, 3'b011, r_rd, 7'b0000011};
      OP_LW:   w_word = {r_imm[11:0], r_rs1, 3'b010, r_rd, 7'b0000011};
      OP_SD:   w_word = {r_imm[11:5], r_rs2, r_rs1, 3'b011, r_imm[4:0], 7'b0100011};
      OP_SW:   w_word = {r_imm[11:5], r_rs2, r_rs1, 3'b010, r_imm[4:0], 7'b0100011};
      OP_ADDI: w_word = {r_imm[11:0], r_rs1, 3'b000, r_rd, 7'b0010011};
      OP_SLTI: w_word = {r_imm[11:0], r_rs1, 3'b010, r_rd, 7'b0010011};
      OP_JALR: w_word = {r_imm[11:0], r_rs1, 3'b000, r_rd, 7'b1100111};
      OP_BEQ:  w_word = {r_imm[11], r_imm[9:4], r_rs2, r_rs1, 3'b000,
                         r_imm[3:0], r_imm[10], 7'b1100011};
      OP_JAL: begin
        w_word     = {r_imm[19], r_imm[9:0], r_imm[10], r_imm[18:11],
                      r_rd, 7'b1101111};
        w_range_ok = w_long_ok;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Sequencing: IDLE -> ENC -> WRITE|ERR -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) r_state <= S_ENC;
        S_ENC:   r_state <= (w_illegal || !w_range_ok) ? S_ERR : S_WRITE;
        S_WRITE: if (mem_ack) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture the request so the upstream driver is free after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_rd  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_imm <= '0;
    end else if (w_accept) begin
      r_op  <= in_op;
      r_rd  <= in_rd;
      r_rs1 <= in_rs1;
      r_rs2 <= in_rs2;
      r_imm <= in_imm;
    end
  end

  // Write pointer: word-aligned reload in IDLE, advance on acknowledged write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (r_state == S_IDLE && addr_load) begin
      r_ptr <= {addr_in[ADDR_W-1:2], 2'b00};
    end else if (r_state == S_WRITE && mem_ack) begin
      r_ptr <= r_ptr + ADDR_W'(4);
    end
  end

  // Encoded word and error code are registered at the end of ENC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdata    <= '0;
      r_err_code <= '0;
    end else if (r_state == S_ENC) begin
      if (w_illegal)        r_err_code <= ERR_ILLEGAL;
      else if (!w_range_ok) r_err_code <= ERR_RANGE;
      else                  r_wdata    <= w_word;
    end
  end

  // Saturating count of completed writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_state == S_WRITE && mem_ack && r_count != 16'hFFFF) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign mem_we     = (r_state == S_WRITE);
  assign err        = (r_state == S_ERR);
  assign mem_addr   = r_ptr;
  assign mem_wdata  = r_wdata;
  assign err_code   = r_err_code;
  assign inst_count = r_count;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: directed scenarios plus a randomized run
// checked against an arithmetic encoding model.
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [63:0] in_imm = '0;
  logic        addr_load = 1'b0;
  logic [7:0]  addr_in = '0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] inst_count;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0]  m_ptr = '0;
  int          m_count = 0;
  logic [1:0]  m_code = '0;

  // observations captured by send()
  logic        g_we, g_err, g_stable, g_ready_after, g_we_after, g_err_after, g_timeout;
  logic [7:0]  g_addr;
  logic [31:0] g_data;
  logic [1:0]  g_code;

  inst_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .addr_load(addr_load), .addr_in(addr_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .err(err), .err_code(err_code), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  // Instruction word built directly from the RV64I field layout
  function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1,
                                          input int rs2, input longint imm);
    longint w;
    longint f3;
    longint opc;
    case (op)
      0: begin f3 = 3; opc = 'h03; end
      1: begin f3 = 2; opc = 'h03; end
      2: begin f3 = 3; opc = 'h23; end
      3: begin f3 = 2; opc = 'h23; end
      4: begin f3 = 0; opc = 'h13; end
      5: begin f3 = 2; opc = 'h13; end
      6: begin f3 = 0; opc = 'h67; end
      7: begin f3 = 0; opc = 'h63; end
      default: begin f3 = 0; opc = 'h6F; end
    endcase
    if (op <= 1 || (op >= 4 && op <= 6))
      w = ((imm & 'hFFF) << 20) | (longint'(rs1) << 15) | (f3 << 12) | (longint'(rd) << 7) | opc;
    else if (op <= 3)
      w = (((imm >> 5) & 'h7F) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15)
        | (f3 << 12) | ((imm & 'h1F) << 7) | opc;
    else if (op == 7)
      w = (((imm >> 11) & 1) << 31) | (((imm >> 4) & 'h3F) << 25) | (longint'(rs2) << 20)
        | (longint'(rs1) << 15) | ((imm & 'hF) << 8) | (((imm >> 10) & 1) << 7) | opc;
    else
      w = (((imm >> 19) & 1) << 31) | ((imm & 'h3FF) << 21) | (((imm >> 10) & 1) << 20)
        | (((imm >> 11) & 'hFF) << 12) | (longint'(rd) << 7) | opc;
    return w[31:0];
  endfunction

  // Expected error code: 0 = legal, 1 = illegal op, 2 = out of range
  function automatic logic [1:0] ref_code(input int op, input longint imm);
    if (op > 8) return 2'b01;
    if (op == 8) return (imm >= -524288 && imm <= 524287) ? 2'b00 : 2'b10;
    return (imm >= -2048 && imm <= 2047) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write();
    m_ptr   = m_ptr + 8'd4;
    m_count = (m_count < 65535) ? m_count + 1 : m_count;
  endtask

  // Issue one request and record what the DUT does; ack_wait = cycles of held-off ack
  task automatic send(input int op, input int rd, input int rs1, input int rs2,
                      input longint imm, input logic ld, input logic [7:0] la,
                      input int ack_wait);
    int n;
    n = 0;
    g_timeout = 1'b0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = 4'(op);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
    addr_load = ld;
    addr_in   = la;
    mem_ack   = (ack_wait == 0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    addr_load = 1'b0;
    in_op     = 4'($urandom);
    in_rd     = 5'($urandom);
    in_rs1    = 5'($urandom);
    in_rs2    = 5'($urandom);
    in_imm    = {$urandom, $urandom};
    addr_in   = 8'($urandom);
    @(posedge clk); #1;
    g_we = mem_we; g_err = err; g_addr = mem_addr; g_data = mem_wdata; g_code = err_code;
    g_stable = 1'b1; g_we_after = 1'b0; g_err_after = 1'b0;
    if (mem_we === 1'b1) begin
      for (int k = 0; k < ack_wait; k++) begin
        @(negedge clk);
        if (mem_we !== 1'b1 || mem_addr !== g_addr || mem_wdata !== g_data || in_ready !== 1'b0)
          g_stable = 1'b0;
        @(posedge clk); #1;
        if (mem_we !== 1'b1 || mem_addr !== g_addr || mem_wdata !== g_data)
          g_stable = 1'b0;
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      g_we_after = mem_we;
    end else begin
      mem_ack = 1'b0;
      @(posedge clk); #1;
      g_err_after = err;
    end
    g_ready_after = in_ready;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) g_timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, mem_we, err} !== 3'b100) begin
      errors++; $display("FAIL reset_ctrl got ready/we/err=%b want 100", {in_ready, mem_we, err});
    end
    checks++;
    if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem got addr=%h data=%h want 00/00000000", mem_addr, mem_wdata);
    end
    checks++;
    if (err_code !== 2'b00 || inst_count !== 16'h0) begin
      errors++; $display("FAIL reset_status got code=%b count=%0d want 00/0", err_code, inst_count);
    end
    rst_n = 1'b1;
    m_ptr = '0; m_count = 0; m_code = '0;
    @(negedge clk);
  endtask

  task automatic test_addi_basic();
    send(4, 5, 0, 0, -1, 1'b0, 8'h00, 0);
    checks++;
    if (g_we !== 1'b1 || g_addr !== 8'h00 || g_data !== 32'hFFF00293) begin
      errors++; $display("FAIL addi_write got we=%b addr=%h data=%h want 1/00/fff00293", g_we, g_addr, g_data);
    end
    model_write();
    checks++;
    if (g_we_after !== 1'b0 || g_ready_after !== 1'b1) begin
      errors++; $display("FAIL addi_latency got we_after=%b ready_after=%b want 0/1", g_we_after, g_ready_after);
    end
    checks++;
    if (inst_count !== 16'(m_count)) begin
      errors++; $display("FAIL addi_count got %0d want %0d", inst_count, m_count);
    end
  endtask

  task automatic test_store_branch();
    send(2, 0, 2, 6, 8, 1'b0, 8'h00, 0);
    checks++;
    if (g_addr !== m_ptr || g_data !== 32'h00613423) begin
      errors++; $display("FAIL sd_write got addr=%h data=%h want %h/00613423", g_addr, g_data, m_ptr);
    end
    model_write();
    send(7, 0, 1, 2, 4, 1'b0, 8'h00, 0);
    checks++;
    if (g_addr !== m_ptr || g_data !== 32'h00208463) begin
      errors++; $display("FAIL beq_write got addr=%h data=%h want %h/00208463", g_addr, g_data, m_ptr);
    end
    model_write();
  endtask

  task automatic test_addr_load_wrap();
    send(8, 1, 0, 0, 2, 1'b1, 8'hFE, 0);
    m_ptr = 8'hFC;
    checks++;
    if (g_addr !== 8'hFC || g_data !== 32'h004000EF) begin
      errors++; $display("FAIL jal_load got addr=%h data=%h want fc/004000ef", g_addr, g_data);
    end
    model_write();
    send(4, 3, 4, 0, 5, 1'b0, 8'h00, 0);
    checks++;
    if (g_addr !== 8'h00 || g_data !== ref_enc(4, 3, 4, 0, 5)) begin
      errors++; $display("FAIL wrap_write got addr=%h data=%h want 00/%h", g_addr, g_data, ref_enc(4, 3, 4, 0, 5));
    end
    model_write();
    checks++;
    if (inst_count !== 16'(m_count)) begin
      errors++; $display("FAIL wrap_count got %0d want %0d", inst_count, m_count);
    end
  endtask

  task automatic test_errors();
    longint imms[4] = '{2048, -2049, 524288, 0};
    int     ops[4]  = '{4, 3, 8, 12};
    logic [1:0] want[4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], 7, 8, 9, imms[i], 1'b0, 8'h00, 0);
      m_code = want[i];
      checks++;
      if (g_err !== 1'b1 || g_we !== 1'b0 || g_code !== want[i] || g_err_after !== 1'b0) begin
        errors++; $display("FAIL err_case%0d got err=%b we=%b code=%b err_after=%b want 1/0/%b/0",
                           i, g_err, g_we, g_code, g_err_after, want[i]);
      end
      checks++;
      if (mem_addr !== m_ptr || inst_count !== 16'(m_count) || err_code !== want[i]) begin
        errors++; $display("FAIL err_state%0d got addr=%h count=%0d code=%b want %h/%0d/%b",
                           i, mem_addr, inst_count, err_code, m_ptr, m_count, want[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    int     ops[4]  = '{4, 3, 8, 7};
    longint imms[4] = '{2047, -2048, -524288, -2048};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], 10, 11, 12, imms[i], 1'b0, 8'h00, 0);
      checks++;
      if (g_we !== 1'b1 || g_err !== 1'b0 || g_addr !== m_ptr
          || g_data !== ref_enc(ops[i], 10, 11, 12, imms[i])) begin
        errors++; $display("FAIL boundary%0d got we=%b addr=%h data=%h want 1/%h/%h", i, g_we, g_addr,
                           g_data, m_ptr, ref_enc(ops[i], 10, 11, 12, imms[i]));
      end
      model_write();
    end
  endtask

  task automatic test_stall();
    send(0, 9, 3, 0, -16, 1'b0, 8'h00, 5);
    checks++;
    if (g_we !== 1'b1 || g_stable !== 1'b1) begin
      errors++; $display("FAIL stall_hold got we=%b stable=%b want 1/1", g_we, g_stable);
    end
    checks++;
    if (g_addr !== m_ptr || g_data !== ref_enc(0, 9, 3, 0, -16) || g_we_after !== 1'b0) begin
      errors++; $display("FAIL stall_write got addr=%h data=%h we_after=%b want %h/%h/0",
                         g_addr, g_data, g_we_after, m_ptr, ref_enc(0, 9, 3, 0, -16));
    end
    model_write();
    checks++;
    if (inst_count !== 16'(m_count)) begin
      errors++; $display("FAIL stall_count got %0d want %0d", inst_count, m_count);
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd4; in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd0; in_imm = 64'd7;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got we=%b want 1", mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || inst_count !== 16'h0 || mem_addr !== 8'h00) begin
      errors++; $display("FAIL midrst_clear got we=%b count=%0d addr=%h want 0/0/00", mem_we, inst_count, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = '0; m_count = 0; m_code = '0;
    send(4, 1, 2, 0, 7, 1'b0, 8'h00, 0);
    checks++;
    if (g_addr !== 8'h00 || g_data !== ref_enc(4, 1, 2, 0, 7) || inst_count !== 16'd1) begin
      errors++; $display("FAIL midrst_next got addr=%h data=%h count=%0d want 00/%h/1",
                         g_addr, g_data, inst_count, ref_enc(4, 1, 2, 0, 7));
    end
    model_write();
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int op, rd, rs1, rs2, aw;
      longint v;
      logic ld;
      logic [7:0] la;
      logic [1:0] code;
      op  = $urandom_range(0, 11);
      rd  = $urandom_range(0, 31);
      rs1 = $urandom_range(0, 31);
      rs2 = $urandom_range(0, 31);
      case ($urandom_range(0, 4))
        0: v = longint'($urandom_range(0, 4095)) - 2048;
        1: v = ($urandom_range(0, 1) == 1) ? 2048 + longint'($urandom_range(0, 3))
                                           : -2049 - longint'($urandom_range(0, 3));
        2: v = longint'($urandom_range(0, 1048575)) - 524288;
        3: v = ($urandom_range(0, 1) == 1) ? 524288 : -524289;
        default: v = {$urandom, $urandom};
      endcase
      ld = ($urandom_range(0, 3) == 0);
      la = 8'($urandom);
      aw = $urandom_range(0, 2);
      send(op, rd, rs1, rs2, v, ld, la, aw);
      if (ld) m_ptr = la & 8'hFC;
      code = ref_code(op, v);
      checks++;
      if (code != 2'b00) begin
        m_code = code;
        if (g_err !== 1'b1 || g_we !== 1'b0 || g_code !== code) begin
          errors++; $display("FAIL rand%0d_err op=%0d imm=%0d got err=%b we=%b code=%b want 1/0/%b",
                             it, op, v, g_err, g_we, g_code, code);
        end
      end else begin
        if (g_we !== 1'b1 || g_addr !== m_ptr || g_data !== ref_enc(op, rd, rs1, rs2, v) || g_stable !== 1'b1) begin
          errors++; $display("FAIL rand%0d_write op=%0d imm=%0d got we=%b addr=%h data=%h stable=%b want 1/%h/%h/1",
                             it, op, v, g_we, g_addr, g_data, g_stable, m_ptr, ref_enc(op, rd, rs1, rs2, v));
        end
        model_write();
      end
      checks++;
      if (inst_count !== 16'(m_count) || err_code !== m_code || mem_addr !== m_ptr || g_timeout !== 1'b0) begin
        errors++; $display("FAIL rand%0d_state got count=%0d code=%b addr=%h timeout=%b want %0d/%b/%h/0",
                           it, inst_count, err_code, mem_addr, g_timeout, m_count, m_code, m_ptr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi_basic();
    test_store_branch();
    test_addr_load_wrap();
    test_errors();
    test_boundaries();
    test_stall();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
